// File: rtl/pmu_uart_pkg.sv
// Shared protocol constants, FSM state encoding and ASCII digit helpers
// for the PMU readout UART protocol.
package pmu_uart_pkg;

  localparam logic [7:0] ESCAPE_CHARCTER    = 8'h0D;
  localparam logic [7:0] CLEAN_CHARCTER     = 8'h20;
  localparam logic [7:0] LINEFEED           = 8'h0A;
  localparam logic [7:0] NEWLINE            = 8'h0D;
  localparam logic [3:0] ASCII_DIGIT_PREFIX = 4'h3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TX_CLEAN,
    ST_TX_DIGIT,
    ST_TX_ESC,
    ST_RX_HI,
    ST_RX_LO,
    ST_RX_LF,
    ST_RX_CR
  } pmu_state_t;

  // Nibbles 10..15 map onto 0x3A..0x3F rather than letters.
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
    return {ASCII_DIGIT_PREFIX, nibble};
  endfunction

  function automatic logic ascii_is_digit(input logic [7:0] b);
    return (b[7:4] == ASCII_DIGIT_PREFIX);
  endfunction

endpackage

// File: rtl/pmu_query_master.sv
// PMU readout query initiator: sends clean/index/escape bytes, parses the 4-byte reply.
// Optional response timeout is enabled by defining PMU_QUERY_TIMEOUT_EN.
//
// state       | meaning
// IDLE        | ready for a request, stray received bytes dropped
// TX_CLEAN    | sending clean character
// TX_DIGIT    | sending index digits, MSB digit first
// TX_ESC      | sending command terminator
// RX_HI/RX_LO | expecting high/low value digit
// RX_LF/RX_CR | expecting line feed / carriage return
module pmu_query_master
  import pmu_uart_pkg::*;
#(
  parameter int COUNTERSIZE    = 8,
  parameter int REGISTER_SIZE  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [REGISTER_SIZE-1:0] req_reg,
  input  logic                     req_valid,
  output logic                     req_ready,
  output logic [7:0]               m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic [7:0]               s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [COUNTERSIZE-1:0]   rsp_value,
  output logic                     rsp_valid,
  output logic                     rsp_error,
  output logic                     busy
);

  localparam int NDIG  = (REGISTER_SIZE + 3) / 4;
  localparam int REQ_W = NDIG * 4;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  pmu_state_t             r_state;
  pmu_state_t             w_state_nxt;
  logic [REQ_W-1:0]       r_req;
  logic [IDX_W-1:0]       r_idx;
  logic [3:0]             r_hi;
  logic [3:0]             r_lo;
  logic [COUNTERSIZE-1:0] r_rsp_value;
  logic                   r_rsp_valid;
  logic                   r_rsp_error;

  logic [3:0] w_nib;
  logic [7:0] w_tdata;
  logic       w_tvalid;
  logic       w_rx_ready;
  logic       w_in_rx;
  logic       w_rx_fire;
  logic       w_tmo_hit;
  logic       w_ok;
  logic       w_err;

  assign w_nib     = r_req[{r_idx, 2'b00} +: 4];
  assign w_in_rx   = (r_state == ST_RX_HI) || (r_state == ST_RX_LO) ||
                     (r_state == ST_RX_LF) || (r_state == ST_RX_CR);
  assign w_rx_fire = s_axis_tvalid && w_rx_ready;

`ifdef PMU_QUERY_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo;

  // Cleared outside RX and on every accepted byte, so it measures silence on the line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_tmo <= '0;
    else if (!w_in_rx || w_rx_fire) r_tmo <= '0;
    else if (!w_tmo_hit)           r_tmo <= r_tmo + 1'b1;
  end

  assign w_tmo_hit = w_in_rx && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_tdata     = 8'h00;
    w_tvalid    = 1'b0;
    w_rx_ready  = 1'b0;
    w_ok        = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_rx_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_TX_CLEAN;
      end
      ST_TX_CLEAN: begin
        w_tdata  = CLEAN_CHARCTER;
        w_tvalid = 1'b1;
        if (m_axis_tready) w_state_nxt = ST_TX_DIGIT;
      end
      ST_TX_DIGIT: begin
        w_tdata  = hex_to_ascii(w_nib);
        w_tvalid = 1'b1;
        if (m_axis_tready && (r_idx == '0)) w_state_nxt = ST_TX_ESC;
      end
      ST_TX_ESC: begin
        w_tdata  = ESCAPE_CHARCTER;
        w_tvalid = 1'b1;
        if (m_axis_tready) w_state_nxt = ST_RX_HI;
      end
      ST_RX_HI, ST_RX_LO: begin
        w_rx_ready = 1'b1;
        if (s_axis_tvalid) begin
          if (!ascii_is_digit(s_axis_tdata)) w_err = 1'b1;
          else w_state_nxt = (r_state == ST_RX_HI) ? ST_RX_LO : ST_RX_LF;
        end
      end
      ST_RX_LF: begin
        w_rx_ready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tdata == LINEFEED) w_state_nxt = ST_RX_CR;
          else w_err = 1'b1;
        end
      end
      ST_RX_CR: begin
        w_rx_ready = 1'b1;
        if (s_axis_tvalid) begin
          if (s_axis_tdata == NEWLINE) w_ok = 1'b1;
          else w_err = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A byte landing on the timeout cycle takes priority over the timeout.
    if (w_tmo_hit && !s_axis_tvalid) w_err = 1'b1;
    if (w_ok || w_err) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_req       <= '0;
      r_idx       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_rsp_value <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_ok;
      r_rsp_error <= w_err;
      if ((r_state == ST_IDLE) && req_valid) r_req <= REQ_W'(req_reg);
      if ((r_state == ST_TX_CLEAN) && m_axis_tready) r_idx <= IDX_W'(NDIG - 1);
      if ((r_state == ST_TX_DIGIT) && m_axis_tready && (r_idx != '0)) r_idx <= r_idx - 1'b1;
      if ((r_state == ST_RX_HI) && s_axis_tvalid) r_hi <= s_axis_tdata[3:0];
      if ((r_state == ST_RX_LO) && s_axis_tvalid) r_lo <= s_axis_tdata[3:0];
      if (w_ok) r_rsp_value <= COUNTERSIZE'({r_hi, r_lo});
    end
  end

  assign req_ready     = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign m_axis_tdata  = w_tdata;
  assign m_axis_tvalid = w_tvalid;
  assign s_axis_tready = w_rx_ready;
  assign rsp_value     = r_rsp_value;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_error     = r_rsp_error;

endmodule

// File: tb/tb_pmu_query_master.sv
// Directed bench for pmu_query_master: vector table of queries/responses plus
// hand-written stall, reset, ignored-request and (optional) timeout sequences.
module tb_pmu_query_master;

  localparam int TMO = 50;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_reg;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] rsp_value;
  logic       rsp_valid;
  logic       rsp_error;
  logic       busy;

  pmu_query_master #(.COUNTERSIZE(8), .REGISTER_SIZE(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_reg(req_reg), .req_valid(req_valid), .req_ready(req_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .rsp_value(rsp_value), .rsp_valid(rsp_valid), .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] reg_sel;
    logic [7:0] cmd;
    int         nbytes;
    logic [7:0] b [4];
    int         err_at;
    logic [7:0] exp_value;
  } vec_t;

  vec_t       vecs [9];
  vec_t       v;
  logic [7:0] tx_q [$];
  int         total = 0;
  int         bad   = 0;

  always @(posedge clk)
    if (rst && m_axis_tvalid && m_axis_tready) tx_q.push_back(m_axis_tdata);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (s_axis_tready) begin
        ok = 1;
        @(posedge clk);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    if (!ok) check("rx_accept_timeout", 0, 1);
  endtask

  task automatic start_query(input vec_t q);
    bit done = 0;
    tx_q.delete();
    m_axis_tready = 1'b1;
    check("req_ready_idle", req_ready, 1);
    req_reg   = q.reg_sel;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (tx_q.size() >= 3) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) check("tx_byte_timeout", tx_q.size(), 3);
    else check("cmd_bytes", {tx_q[0], tx_q[1], tx_q[2]}, {8'h20, q.cmd, 8'h0D});
    check("tvalid_after_esc", m_axis_tvalid, 0);
  endtask

  task automatic finish_rsp(input vec_t q);
    for (int k = 0; k < q.nbytes; k++) begin
      send_byte(q.b[k]);
      check("err_pulse", rsp_error, (k == q.err_at));
      check("valid_pulse", rsp_valid, (q.err_at < 0) && (k == q.nbytes - 1));
    end
    check("rsp_value", rsp_value, q.exp_value);
    check("busy_end", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'h5, 8'h35, 4, '{8'h3A, 8'h37, 8'h0A, 8'h0D}, -1, 8'hA7};
    vecs[1] = '{4'h0, 8'h30, 4, '{8'h3F, 8'h3F, 8'h0A, 8'h0D}, -1, 8'hFF};
    vecs[2] = '{4'hA, 8'h3A, 4, '{8'h31, 8'h41, 8'h0A, 8'h0D},  1, 8'hFF};
    vecs[3] = '{4'h3, 8'h33, 4, '{8'h12, 8'h34, 8'h0A, 8'h0D},  0, 8'hFF};
    vecs[4] = '{4'h9, 8'h39, 4, '{8'h39, 8'h3C, 8'h0A, 8'h0D}, -1, 8'h9C};
    vecs[5] = '{4'h6, 8'h36, 3, '{8'h30, 8'h32, 8'h0D, 8'h00},  2, 8'h9C};
    vecs[6] = '{4'hC, 8'h3C, 4, '{8'h3B, 8'h32, 8'h0A, 8'h0A},  3, 8'h9C};
    vecs[7] = '{4'h1, 8'h31, 4, '{8'h35, 8'h35, 8'h0A, 8'h0D}, -1, 8'h55};
    vecs[8] = '{4'h7, 8'h37, 4, '{8'h3E, 8'h30, 8'h0A, 8'h0D}, -1, 8'hE0};

    rst = 1'b0; req_reg = 4'h0; req_valid = 1'b0; m_axis_tready = 1'b0;
    s_axis_tdata = 8'h00; s_axis_tvalid = 1'b0;
    #1;
    check("reset_outputs",
          {req_ready, s_axis_tready, m_axis_tvalid, m_axis_tdata, rsp_value, rsp_valid, rsp_error, busy},
          {1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      start_query(vecs[i]);
      finish_rsp(vecs[i]);
      @(negedge clk);
    end

    // Back-pressure mid-command: bytes held stable while tready is low.
    tx_q.delete();
    m_axis_tready = 1'b0;
    req_reg = 4'hF; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stall_clean", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h20});
      check("s_tready_in_tx", s_axis_tready, 0);
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("stall_digit", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h3F});
      @(negedge clk);
    end
    m_axis_tready = 1'b1;
    @(negedge clk);
    check("esc_present", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h0D});
    @(negedge clk);
    check("stall_tvalid_drop", m_axis_tvalid, 0);
    check("stall_cmd", (tx_q.size() == 3) ? {tx_q[0], tx_q[1], tx_q[2]} : 24'h0, {8'h20, 8'h3F, 8'h0D});
    v = '{4'hF, 8'h3F, 4, '{8'h3F, 8'h30, 8'h0A, 8'h0D}, -1, 8'hF0};
    finish_rsp(v);
    @(negedge clk);

    // Reset asserted while a digit is on the wire.
    tx_q.delete();
    m_axis_tready = 1'b0;
    req_reg = 4'h7; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    m_axis_tready = 1'b1;
    @(negedge clk);
    m_axis_tready = 1'b0;
    check("pre_reset_digit", {m_axis_tvalid, m_axis_tdata}, {1'b1, 8'h37});
    rst = 1'b0;
    #1;
    check("midreset_outputs",
          {req_ready, s_axis_tready, m_axis_tvalid, rsp_value, rsp_valid, rsp_error, busy},
          {1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_idle", {busy, rsp_valid, rsp_error}, 3'b000);

    // Recovery query, with a request attempted while busy.
    v = '{4'h2, 8'h32, 4, '{8'h32, 8'h38, 8'h0A, 8'h0D}, -1, 8'h28};
    start_query(v);
    req_reg = 4'hB; req_valid = 1'b1;
    check("req_ready_busy", req_ready, 0);
    @(negedge clk);
    req_valid = 1'b0;
    check("req_ignored", {busy, m_axis_tvalid, 8'(tx_q.size())}, {1'b1, 1'b0, 8'd3});
    finish_rsp(v);
    @(negedge clk);

`ifdef PMU_QUERY_TIMEOUT_EN
    begin
      int seen = 0;
      v = '{4'h4, 8'h34, 1, '{8'h31, 8'h00, 8'h00, 8'h00}, -1, 8'h28};
      start_query(v);
      send_byte(8'h31);
      for (int c = 1; c <= 70; c++) begin
        @(negedge clk);
        if (rsp_error) begin
          seen = c;
          break;
        end
      end
      check("timeout_cycles", seen, TMO);
      check("timeout_value_kept", rsp_value, 8'h28);
      @(negedge clk);
      check("timeout_idle", busy, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
